// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: MemOp encodings, FSM states,
// byte-lane masks and the access legality check.
package lsu_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_t;

    // 1 when the access may go to the bus: known op, naturally aligned,
    // and no unsigned variant on a store.
    function automatic logic access_ok(input logic is_store, input logic [2:0] op,
                                       input logic [1:0] off);
        logic ok;
        case (op)
            MEMOP_B, MEMOP_BU: ok = 1'b1;
            MEMOP_H, MEMOP_HU: ok = ~off[0];
            MEMOP_W:           ok = (off == 2'b00);
            default:           ok = 1'b0;
        endcase
        if (is_store && op[2])
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory bus between the LSU (master) and the memory (slave).
interface lsu_mem_ctrl_if #(parameter int ADDR_W = 32);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store data replication,
// load lane select with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = mem_rdata[{off, 3'b000} +: 8];
    assign half_sel = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    // op[1:0] distinguishes byte/half/word for both signed and unsigned forms
    always_comb begin
        be        = BE_WORD;
        wdata_rep = wdata;
        case (op[1:0])
            2'b00: begin
                be        = BE_BYTE << off;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be        = BE_HALF << off;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        rdata_ext = mem_rdata;
        case (op)
            MEMOP_B:  rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            MEMOP_BU: rdata_ext = {24'h0, byte_sel};
            MEMOP_H:  rdata_ext = {{16{half_sel[15]}}, half_sel};
            MEMOP_HU: rdata_ext = {16'h0, half_sel};
            default:  ;
        endcase
    end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle load/store unit: req/ack data-memory transaction with lane
// steering, extended load return, and error reporting for bad accesses.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic               MemWr,
    input  logic [2:0]         MemOp,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [31:0]        wdata,
    output logic               busy,
    output logic               done,
    output logic [31:0]        rdata,
    output logic               err,
    lsu_mem_ctrl_if.master     mem
);
    lsu_state_t        state, state_nxt;
    logic [2:0]        op_q;
    logic [1:0]        off_q;
    logic              we_q;
    logic              req_ok;
    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [2:0]        al_op;
    logic [1:0]        al_off;
    logic [3:0]        al_be;
    logic [31:0]       al_wdata, al_rdata;

    assign req_ok = access_ok(MemWr, MemOp, addr[1:0]);

    // One aligner serves both phases: live request in IDLE, latched op afterwards
    assign al_op  = (state == ST_IDLE) ? MemOp     : op_q;
    assign al_off = (state == ST_IDLE) ? addr[1:0] : off_q;

    lsu_align u_align (
        .op        (al_op),
        .off       (al_off),
        .wdata     (wdata),
        .mem_rdata (mem.mem_rdata),
        .be        (al_be),
        .wdata_rep (al_wdata),
        .rdata_ext (al_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (req_valid) state_nxt = req_ok ? ST_ACCESS : ST_RESP;
            ST_ACCESS: if (mem.mem_ack) state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= '0;
            off_q       <= '0;
            we_q        <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (req_valid) begin
                    if (req_ok) begin
                        op_q        <= MemOp;
                        off_q       <= addr[1:0];
                        we_q        <= MemWr;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= MemWr;
                        mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                        mem_be_q    <= al_be;
                        mem_wdata_q <= al_wdata;
                    end else begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                ST_ACCESS: if (mem.mem_ack) begin
                    mem_req_q <= 1'b0;
                    err_q     <= 1'b0;
                    rdata_q   <= we_q ? 32'h0 : al_rdata;
                end
                default: ;
            endcase
        end
    end

    assign busy          = ((state == ST_IDLE) && req_valid) || (state == ST_ACCESS);
    assign done          = (state == ST_RESP);
    assign rdata         = rdata_q;
    assign err           = err_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: expected completions are queued at
// request time and checked by a monitor whenever done pulses.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic        chk_rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        MemWr = 1'b0;
    logic [2:0]  MemOp = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, err;
    logic [31:0] rdata;

    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   exp_done = 0;
    exp_t sb_q[$];

    lsu_mem_ctrl_if #(.ADDR_W(32)) mif ();

    lsu_mem_ctrl #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .MemWr     (MemWr),
        .MemOp     (MemOp),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .mem       (mif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("err", {31'b0, err}, {31'b0, e.err});
                if (e.chk_rd) chk("rdata", rdata, e.rd);
            end
        end
    end

    function automatic exp_t mk(input logic [31:0] rd, input logic e, input logic c);
        exp_t x;
        x.rd = rd; x.err = e; x.chk_rd = c;
        return x;
    endfunction

    // Called just after a rising edge with the DUT in IDLE.
    task automatic do_txn(input logic we, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] mrd, input int waits,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
        int cyc;
        int n;
        req_valid = 1'b1; MemWr = we; MemOp = op; addr = a; wdata = wd;
        sb_q.push_back(mk(exp_rd, exp_err, !we || exp_err));
        exp_done++;
        @(negedge clk);
        chk("busy_req", {31'b0, busy}, 32'd1);
        chk("req_early", {31'b0, mif.mem_req}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0; MemOp = 3'b111; addr = 32'hFFFF_FFFF; wdata = 32'h0;
        cyc = 1;
        if (!exp_err) begin
            @(negedge clk);
            chk("mem_req", {31'b0, mif.mem_req}, 32'd1);
            chk("mem_we", {31'b0, mif.mem_we}, {31'b0, we});
            chk("mem_be", {28'b0, mif.mem_be}, {28'b0, exp_be});
            chk("mem_addr", mif.mem_addr, {a[31:2], 2'b00});
            if (we) chk("mem_wdata", mif.mem_wdata, exp_wd);
            for (int w = 0; w < waits; w++) begin
                @(posedge clk); #1;
                cyc++;
                @(negedge clk);
                chk("req_hold", {31'b0, mif.mem_req}, 32'd1);
                chk("be_hold", {28'b0, mif.mem_be}, {28'b0, exp_be});
                chk("busy_wait", {31'b0, busy}, 32'd1);
            end
            mif.mem_ack = 1'b1; mif.mem_rdata = mrd;
            @(posedge clk); #1;
            mif.mem_ack = 1'b0; mif.mem_rdata = 32'hAAAA_AAAA;
            cyc++;
        end
        n = 0;
        while (!done && n < 8) begin
            @(posedge clk); #1;
            n++; cyc++;
        end
        chk("latency", cyc, exp_err ? 32'd1 : 32'(2 + waits));
        @(negedge clk);
        chk("resp_req", {31'b0, mif.mem_req}, 32'd0);
        chk("resp_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int snap;
        mif.mem_ack = 1'b0; mif.mem_rdata = 32'hAAAA_AAAA;
        #12;
        chk("rst_req", {31'b0, mif.mem_req}, 32'd0);
        chk("rst_we", {31'b0, mif.mem_we}, 32'd0);
        chk("rst_be", {28'b0, mif.mem_be}, 32'd0);
        chk("rst_addr", mif.mem_addr, 32'd0);
        chk("rst_wdata", mif.mem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        do_txn(1'b0, MEMOP_W,  32'h100, 0, 32'hDEADBEEF, 2, 32'hDEADBEEF, 1'b0, 4'b1111, 0);
        do_txn(1'b0, MEMOP_B,  32'h103, 0, 32'h80FF0000, 0, 32'hFFFFFF80, 1'b0, 4'b1000, 0);
        do_txn(1'b0, MEMOP_BU, 32'h103, 0, 32'h80FF0000, 1, 32'h00000080, 1'b0, 4'b1000, 0);
        do_txn(1'b0, MEMOP_HU, 32'h102, 0, 32'h80FF0000, 0, 32'h000080FF, 1'b0, 4'b1100, 0);
        do_txn(1'b0, MEMOP_H,  32'h102, 0, 32'h80FF0000, 0, 32'hFFFF80FF, 1'b0, 4'b1100, 0);
        do_txn(1'b0, MEMOP_H,  32'h100, 0, 32'h12348765, 0, 32'hFFFF8765, 1'b0, 4'b0011, 0);
        do_txn(1'b1, MEMOP_B,  32'h201, 32'h12345678, 0, 0, 0, 1'b0, 4'b0010, 32'h78787878);
        do_txn(1'b1, MEMOP_H,  32'h202, 32'h12345678, 0, 1, 0, 1'b0, 4'b1100, 32'h56785678);
        do_txn(1'b1, MEMOP_W,  32'h204, 32'h12345678, 0, 0, 0, 1'b0, 4'b1111, 32'h12345678);
        do_txn(1'b0, MEMOP_W,  32'h102, 0, 0, 0, 32'h0, 1'b1, 4'b0000, 0);
        do_txn(1'b0, MEMOP_BU, 32'h101, 0, 32'h0000A500, 0, 32'h000000A5, 1'b0, 4'b0010, 0);
        do_txn(1'b1, MEMOP_BU, 32'h200, 32'h1, 0, 0, 32'h0, 1'b1, 4'b0000, 0);
        do_txn(1'b0, 3'b011,   32'h100, 0, 0, 0, 32'h0, 1'b1, 4'b0000, 0);
        do_txn(1'b0, MEMOP_HU, 32'h101, 0, 0, 0, 32'h0, 1'b1, 4'b0000, 0);

        // Reset during ACCESS: bus request must fall without waiting for a clock.
        req_valid = 1'b1; MemWr = 1'b0; MemOp = MEMOP_W; addr = 32'h300;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("acc_req", {31'b0, mif.mem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_req", {31'b0, mif.mem_req}, 32'd0);
        chk("async_busy", {31'b0, busy}, 32'd0);
        snap = done_cnt;
        @(posedge clk); #1;
        rst = 1'b0;
        mif.mem_ack = 1'b1;
        @(posedge clk); #1;
        mif.mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("no_done_rst", done_cnt, snap);
        do_txn(1'b0, MEMOP_W, 32'h300, 0, 32'hCAFEF00D, 1, 32'hCAFEF00D, 1'b0, 4'b1111, 0);

        // req_valid held through RESP: second access starts only from IDLE.
        req_valid = 1'b1; MemWr = 1'b0; MemOp = MEMOP_W; addr = 32'h400;
        sb_q.push_back(mk(32'h11111111, 1'b0, 1'b1));
        exp_done++;
        @(posedge clk); #1;
        addr = 32'h404;
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h11111111;
        @(posedge clk); #1;
        mif.mem_ack = 1'b0;
        chk("hold_done1", {31'b0, done}, 32'd1);
        @(negedge clk);
        chk("hold_resp_req", {31'b0, mif.mem_req}, 32'd0);
        chk("hold_resp_busy", {31'b0, busy}, 32'd0);
        sb_q.push_back(mk(32'h22222222, 1'b0, 1'b1));
        exp_done++;
        @(posedge clk); #1;
        chk("hold_idle_done", {31'b0, done}, 32'd0);
        chk("hold_idle_req", {31'b0, mif.mem_req}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("hold2_req", {31'b0, mif.mem_req}, 32'd1);
        chk("hold2_addr", mif.mem_addr, 32'h404);
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h22222222;
        @(posedge clk); #1;
        mif.mem_ack = 1'b0;
        chk("hold_done2", {31'b0, done}, 32'd1);
        @(posedge clk); #1;
        chk("hold_after", {31'b0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;

        chk("done_count", done_cnt, exp_done);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
